// File: rtl/dot_row_collector_if.sv
// Handshake bundle between the dot-product accumulator, the row collector and write-back.
// The collector uses the slave modport; the driving environment uses master.
interface dot_row_collector_if #(
  parameter int unsigned IDX_W = 6
);
  logic [31:0]      sum_in;
  logic             sum_valid;
  logic [31:0]      res_data;
  logic [IDX_W-1:0] res_idx;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output sum_in,
    output sum_valid,
    output res_ready,
    input  res_data,
    input  res_idx,
    input  res_valid
  );

  modport slave (
    input  sum_in,
    input  sum_valid,
    input  res_ready,
    output res_data,
    output res_idx,
    output res_valid
  );
endinterface

// File: rtl/dot_row_collector.sv
// Captures the final chunk sum of each matrix row, tags it with its row index and
// buffers it in a small FIFO drained over a valid/ready handshake.
module dot_row_collector #(
  parameter int unsigned CHUNKS_PER_ROW = 4,
  parameter int unsigned N_ROWS         = 64,
  parameter int unsigned IDX_W          = 6,
  parameter int unsigned DEPTH          = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  dot_row_collector_if.slave  bus,
  output logic                all_done,
  output logic                overflow
);

  localparam int unsigned CW = (CHUNKS_PER_ROW > 1) ? $clog2(CHUNKS_PER_ROW) : 1;
  localparam int unsigned RW = $clog2(N_ROWS + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [CW-1:0] LastChunk = CW'(CHUNKS_PER_ROW - 1);
  localparam logic [RW-1:0] RowsTotal = RW'(N_ROWS);
  localparam logic [AW:0]   FullCnt   = (AW + 1)'(DEPTH);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StDrain   = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    chunk_q, chunk_d;
  logic [RW-1:0]    row_q, row_d;
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             ovf_q;

  logic [31:0]      mem_data [DEPTH];
  logic [IDX_W-1:0] mem_idx  [DEPTH];

  logic collect, row_final, pop, full, push, drop;

  // Strobes beyond the last row (one cycle before leaving COLLECT) are ignored.
  assign collect   = (state_q == StCollect) && (row_q != RowsTotal);
  assign row_final = collect && bus.sum_valid && (chunk_q == LastChunk);
  assign pop       = (cnt_q != '0) && bus.res_ready;
  assign full      = (cnt_q == FullCnt);
  assign push      = row_final && (!full || pop);
  assign drop      = row_final && full && !pop;

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    row_d   = row_q;
    case (state_q)
      StIdle:    if (start) state_d = StCollect;
      StCollect: if (row_q == RowsTotal) state_d = StDrain;
      StDrain:   if (cnt_q == '0) state_d = StDone;
      StDone:    state_d = StDone;
      default:   state_d = StIdle;
    endcase
    if (collect && bus.sum_valid) begin
      if (chunk_q == LastChunk) begin
        chunk_d = '0;
        row_d   = row_q + RW'(1);
      end else begin
        chunk_d = chunk_q + CW'(1);
      end
    end
    if (!start) begin
      state_d = StIdle;
      chunk_d = '0;
      row_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      chunk_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      row_q   <= row_d;
    end
  end

  // A low start flushes the FIFO and clears the sticky overflow ahead of any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (!start) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_q] <= bus.sum_in;
      mem_idx[wr_q]  <= IDX_W'(row_q);
    end
  end

  // Head is gated so outputs read zero whenever the FIFO is empty.
  assign bus.res_valid = (cnt_q != '0);
  assign bus.res_data  = bus.res_valid ? mem_data[rd_q] : '0;
  assign bus.res_idx   = bus.res_valid ? mem_idx[rd_q] : '0;
  assign all_done      = (state_q == StDone);
  assign overflow      = ovf_q;

endmodule
